// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side is the arbiter; the slave side is the requester/consumer.
interface rr_onehot_arbiter_if #(
  parameter int unsigned N = 8
) ();
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic          ack;
  logic [N-1:0]  grant;
  logic          enable;
  logic          timeout;
  logic [PW-1:0] ptr;

  modport master (
    input  req,
    input  ack,
    output grant,
    output enable,
    output timeout,
    output ptr
  );

  modport slave (
    output req,
    output ack,
    input  grant,
    input  enable,
    input  timeout,
    input  ptr
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until ack or timeout.
// Grant is either all-zero or exactly one-hot, so it can feed a one-hot encoder directly.
module rr_onehot_arbiter #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 5
) (
  input logic                 clk,
  input logic                 reset,
  rr_onehot_arbiter_if.master bus
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] IdxLast = PW'(N - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          enable_q, enable_d;
  logic          timeout_q, timeout_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic          release_ack;
  logic          release_to;

  // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N is correct.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!sel_found && bus.req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(idx);
      end
    end
  end

  assign release_ack = (state_q == StGrant) && bus.ack;
  assign release_to  = (state_q == StGrant) && !bus.ack && (TIMEOUT != 0) && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      enable_q  <= enable_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sel_found) state_d = StGrant;
      StGrant: if (release_ack || release_to) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    enable_d  = enable_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          enable_d         = 1'b1;
          gidx_d           = sel_idx;
          cnt_d            = '0;
        end
      end
      StGrant: begin
        if (release_ack || release_to) begin
          grant_d   = '0;
          enable_d  = 1'b0;
          timeout_d = release_to;
          ptr_d     = (gidx_q == IdxLast) ? '0 : gidx_q + PW'(1);
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        grant_d  = '0;
        enable_d = 1'b0;
      end
    endcase
  end

  assign bus.grant   = grant_q;
  assign bus.enable  = enable_q;
  assign bus.timeout = timeout_q;
  assign bus.ptr     = ptr_q;
endmodule
